// File: rtl/ifu_line_fill.sv
// Instruction-fetch line fill engine.
// Accepts a cache miss, fetches the four 32-bit words of the 16-byte line one
// request at a time, assembles them into a 128-bit line and pulses
// insLineValidOut when the line is complete. A response wait that lasts
// TIMEOUT_CYCLES aborts the fill with a one-cycle fillErr pulse.
// Optional build macro IFU_CRITICAL_WORD_FIRST_EN: when defined, the fill
// starts at the missed word and wraps around the line; otherwise the words
// are always fetched in order 0..3.
module ifu_line_fill #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         Clock,
    input  logic         Rst,
    input  logic         missReq,
    input  logic [31:0]  missPc,
    output logic         missReady,
    output logic         memReqValid,
    output logic [31:0]  memReqAddr,
    input  logic         memReqReady,
    input  logic         memRspValid,
    input  logic [31:0]  memRspData,
    output logic [127:0] insLineOut,
    output logic         insLineValidOut,
    output logic [31:0]  fillPc,
    output logic         fillErr
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen in the last allowed WAIT cycle.
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     word_cnt_q, word_cnt_d;
    logic [1:0]     word_idx_q, word_idx_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic [127:0]   line_q, line_d;
    logic [31:0]    fill_pc_q, fill_pc_d;
    logic [1:0]     start_idx;

`ifdef IFU_CRITICAL_WORD_FIRST_EN
    assign start_idx = missPc[3:2];
    logic unused_pc;
    assign unused_pc = ^missPc[1:0];
`else
    assign start_idx = 2'd0;
    logic unused_pc;
    assign unused_pc = ^missPc[3:0];
`endif

    assign insLineOut = line_q;
    assign fillPc     = fill_pc_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            to_cnt_q   <= '0;
            line_q     <= '0;
            fill_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
            to_cnt_q   <= to_cnt_d;
            line_q     <= line_d;
            fill_pc_q  <= fill_pc_d;
        end
    end

    // Next-state logic and Moore/Mealy outputs of the fill FSM.
    always_comb begin
        state_d         = state_q;
        word_cnt_d      = word_cnt_q;
        word_idx_d      = word_idx_q;
        to_cnt_d        = to_cnt_q;
        line_d          = line_q;
        fill_pc_d       = fill_pc_q;
        missReady       = 1'b0;
        memReqValid     = 1'b0;
        memReqAddr      = '0;
        insLineValidOut = 1'b0;
        fillErr         = 1'b0;

        unique case (state_q)
            StIdle: begin
                missReady = 1'b1;
                if (missReq) begin
                    fill_pc_d  = missPc;
                    word_cnt_d = '0;
                    word_idx_d = start_idx;
                    state_d    = StReq;
                end
            end
            StReq: begin
                // Responses are never taken here, so a response in the
                // handshake cycle is dropped.
                memReqValid = 1'b1;
                memReqAddr  = {fill_pc_q[31:4], word_idx_q, 2'b00};
                if (memReqReady) begin
                    to_cnt_d = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (memRspValid) begin
                    line_d[{word_idx_q, 5'b0} +: 32] = memRspData;
                    word_idx_d = word_idx_q + 2'd1;
                    word_cnt_d = word_cnt_q + 2'd1;
                    state_d    = (word_cnt_q == 2'd3) ? StDone : StReq;
                end else if (to_cnt_q == ToLast) begin
                    fillErr = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StDone: begin
                insLineValidOut = 1'b1;
                state_d         = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu_line_fill.sv
// Directed bench for ifu_line_fill: reset state, zero-wait fill, request
// backpressure, response timeout, reset mid-fill and held miss requests.
module tb_ifu_line_fill;

    localparam int unsigned TO  = 8;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;

    logic         Clock = 1'b0;
    logic         Rst;
    logic         missReq;
    logic [31:0]  missPc;
    logic         missReady;
    logic         memReqValid;
    logic [31:0]  memReqAddr;
    logic         memReqReady;
    logic         memRspValid;
    logic [31:0]  memRspData;
    logic [127:0] insLineOut;
    logic         insLineValidOut;
    logic [31:0]  fillPc;
    logic         fillErr;

    ifu_line_fill #(.TIMEOUT_CYCLES(TO)) dut (
        .Clock           (Clock),
        .Rst             (Rst),
        .missReq         (missReq),
        .missPc          (missPc),
        .missReady       (missReady),
        .memReqValid     (memReqValid),
        .memReqAddr      (memReqAddr),
        .memReqReady     (memReqReady),
        .memRspValid     (memRspValid),
        .memRspData      (memRspData),
        .insLineOut      (insLineOut),
        .insLineValidOut (insLineValidOut),
        .fillPc          (fillPc),
        .fillErr         (fillErr)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: data is the address of the last accepted request ^ KEY.
    logic [31:0] pend_addr = '0;
    logic [31:0] addr_log[$];
    int          hs_cnt     = 0;
    int          stall_at   = -1;
    int          stall_seen = 0;
    int          valid_cnt  = 0;
    int          err_cnt    = 0;
    int          excl_viol  = 0;
    bit          rsp_en     = 1'b0;

    assign memRspValid = rsp_en;
    assign memRspData  = pend_addr ^ KEY;
    assign memReqReady = !((hs_cnt == stall_at) && (stall_seen < 3));

    always @(posedge Clock) begin
        if (memReqValid && memReqReady) begin
            addr_log.push_back(memReqAddr);
            pend_addr <= memReqAddr;
            hs_cnt    <= hs_cnt + 1;
        end
        if (memReqValid && !memReqReady) stall_seen <= stall_seen + 1;
        if (insLineValidOut) valid_cnt <= valid_cnt + 1;
        if (fillErr) err_cnt <= err_cnt + 1;
        if (memReqValid && insLineValidOut) excl_viol <= excl_viol + 1;
    end

    function automatic logic [31:0] exp_addr(input logic [31:0] pc, input int k);
        logic [1:0] s;
        logic [1:0] w;
`ifdef IFU_CRITICAL_WORD_FIRST_EN
        s = pc[3:2];
`else
        s = 2'd0;
`endif
        w = s + 2'(k);
        return {pc[31:4], w, 2'b00};
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] b);
        return {(b + 32'd12) ^ KEY, (b + 32'd8) ^ KEY, (b + 32'd4) ^ KEY, b ^ KEY};
    endfunction

    int base;
    int v0;
    int e0;
    int lat;

    // Called at a negedge in IDLE; returns at the negedge of cycle T+1.
    task automatic start_miss(input logic [31:0] pc);
        missPc  = pc;
        missReq = 1'b1;
        check_eq("miss_ready_at_T", missReady, 1'b1);
        base = hs_cnt;
        @(negedge Clock);
        missReq = 1'b0;
    endtask

    // Latency in cycles from acceptance to insLineValidOut, bounded.
    task automatic wait_valid(output int l);
        l = 1;
        while (!insLineValidOut && l < 60) begin
            @(negedge Clock);
            l++;
        end
    endtask

    task automatic check_addrs(input string tag, input logic [31:0] pc);
        check_eq({tag, "_nreq"}, 32'(hs_cnt - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (base + k < addr_log.size())
                check_eq({tag, "_addr"}, addr_log[base + k], exp_addr(pc, k));
        end
    endtask

    initial begin
        Rst     = 1'b1;
        missReq = 1'b0;
        missPc  = '0;
        repeat (3) @(negedge Clock);

        // Reset state.
        check_eq("rst_missReady", missReady, 1'b1);
        check_eq("rst_memReqValid", memReqValid, 1'b0);
        check_eq("rst_memReqAddr", memReqAddr, 32'd0);
        check_eq("rst_lineValid", insLineValidOut, 1'b0);
        check_eq("rst_fillErr", fillErr, 1'b0);
        check_eq("rst_line", insLineOut, 128'd0);
        check_eq("rst_fillPc", fillPc, 32'd0);
        Rst = 1'b0;

        // Stray responses in IDLE do nothing.
        for (int i = 0; i < 4; i++) begin
            rsp_en = (i % 2 == 0);
            @(negedge Clock);
            check_eq("idle_rsp_reqValid", memReqValid, 1'b0);
            check_eq("idle_rsp_line", insLineOut, 128'd0);
        end
        check_eq("idle_rsp_missReady", missReady, 1'b1);

        // Zero-wait fill of 0x1008.
        rsp_en = 1'b1;
        v0 = valid_cnt;
        start_miss(32'h0000_1008);
        wait_valid(lat);
        check_eq("fill_latency", lat, 9);
        check_eq("fill_line", insLineOut,
                 128'hA5A5B5A9_A5A5B5AD_A5A5B5A1_A5A5B5A5);
        check_eq("fill_fillPc", fillPc, 32'h0000_1008);
        check_eq("fill_excl", memReqValid, 1'b0);
        check_addrs("fill", 32'h0000_1008);
        @(negedge Clock);
        check_eq("fill_pulse_width", insLineValidOut, 1'b0);
        check_eq("fill_back_idle", missReady, 1'b1);
        check_eq("fill_valid_count", valid_cnt - v0, 1);

        // Backpressure on the second request.
        stall_at = hs_cnt + 1;
        start_miss(32'h0000_7004);
        lat = 1;
        while (!insLineValidOut && lat < 60) begin
            if (memReqValid && !memReqReady)
                check_eq("stall_addr_stable", memReqAddr, exp_addr(32'h0000_7004, 1));
            @(negedge Clock);
            lat++;
        end
        check_eq("stall_latency", lat, 12);
        check_eq("stall_cycles", stall_seen, 3);
        check_eq("stall_line", insLineOut, line_of(32'h0000_7000));
        check_addrs("stall", 32'h0000_7004);
        @(negedge Clock);

        // Response timeout.
        rsp_en = 1'b0;
        v0 = valid_cnt;
        e0 = err_cnt;
        start_miss(32'h0000_8000);
        lat = 1;
        while (!fillErr && lat < 60) begin
            @(negedge Clock);
            lat++;
        end
        check_eq("to_err_cycle", lat, 9);
        check_eq("to_no_valid_at_err", insLineValidOut, 1'b0);
        @(negedge Clock);
        check_eq("to_err_pulse_width", fillErr, 1'b0);
        check_eq("to_missReady", missReady, 1'b1);
        check_eq("to_err_count", err_cnt - e0, 1);
        check_eq("to_valid_count", valid_cnt - v0, 0);
        check_eq("to_one_request", hs_cnt - base, 1);
        check_eq("to_line_held", insLineOut, line_of(32'h0000_7000));

        // Reset in WAIT of the third word, then a fresh miss at 0x2000.
        rsp_en = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        start_miss(32'h0000_3000);
        repeat (5) @(negedge Clock);
        check_eq("rstmid_three_reqs", hs_cnt - base, 3);
        Rst = 1'b1;
        @(negedge Clock);
        Rst = 1'b0;
        check_eq("rstmid_missReady", missReady, 1'b1);
        check_eq("rstmid_line", insLineOut, 128'd0);
        check_eq("rstmid_fillPc", fillPc, 32'd0);
        base = hs_cnt;
        repeat (3) @(negedge Clock);
        check_eq("rstmid_late_rsp", hs_cnt - base, 0);
        check_eq("rstmid_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 0);
        start_miss(32'h0000_2000);
        wait_valid(lat);
        check_eq("new_latency", lat, 9);
        check_eq("new_line", insLineOut, line_of(32'h0000_2000));
        check_addrs("new", 32'h0000_2000);
        @(negedge Clock);

        // missReq held high with a changing missPc.
        missPc  = 32'h0000_4004;
        missReq = 1'b1;
        check_eq("hold_missReady", missReady, 1'b1);
        base = hs_cnt;
        lat  = 0;
        while (!insLineValidOut && lat < 60) begin
            @(negedge Clock);
            lat++;
            missPc = 32'h0000_5000 + 32'(lat * 16);
            if (!insLineValidOut) check_eq("hold_not_ready", missReady, 1'b0);
        end
        check_eq("hold_latency", lat, 9);
        check_eq("hold_line", insLineOut, line_of(32'h0000_4000));
        check_eq("hold_fillPc", fillPc, 32'h0000_4004);
        check_addrs("hold", 32'h0000_4004);
        missPc = 32'h0000_6000;
        @(negedge Clock);
        check_eq("hold_idle_ready", missReady, 1'b1);
        check_eq("hold_idle_fillPc", fillPc, 32'h0000_4004);
        @(negedge Clock);
        missReq = 1'b0;
        check_eq("hold2_fillPc", fillPc, 32'h0000_6000);
        check_eq("hold2_reqValid", memReqValid, 1'b1);
        check_eq("hold2_addr", memReqAddr, exp_addr(32'h0000_6000, 0));
        base = hs_cnt;
        wait_valid(lat);
        check_eq("hold2_latency", lat, 9);
        check_eq("hold2_line", insLineOut, line_of(32'h0000_6000));
        @(negedge Clock);

        check_eq("req_valid_exclusive", excl_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_line_fill.md
IFU_LINE_FILL -- requirements
Module: ifu_line_fill

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles waiting for one memory response before aborting the fill.
REQ-002 Clock  input  1  clock; all state changes on posedge Clock.
REQ-003 Rst  input  1  reset; synchronous, active-high.
REQ-004 missReq  input  1  cache miss, request to fetch the line containing missPc.
REQ-005 missPc  input  32  miss address; sampled only when missReq & missReady.
REQ-006 missReady  output  1  high only in IDLE; a new miss can be accepted.
REQ-007 memReqValid  output  1  word-read request to memory.
REQ-008 memReqAddr  output  32  word address of the request.
REQ-009 memReqReady  input  1  memory accepts the request.
REQ-010 memRspValid  input  1  read data valid.
REQ-011 memRspData  input  32  read data word.
REQ-012 insLineOut  output  128  assembled line, driven to the instruction cache line input.
REQ-013 insLineValidOut  output  1  one-cycle pulse: insLineOut complete, drives the cache line-valid input.
REQ-014 fillPc  output  32  the missPc captured for the current or last fill.
REQ-015 fillErr  output  1  one-cycle pulse: fill aborted on timeout.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT and DONE.
REQ-017 IDLE->REQ when missReq & missReady: capture fillPc=missPc, wordCnt=0, wordIdx=start index.
REQ-018 In REQ, memReqValid=1 and memReqAddr={fillPc[31:4], wordIdx, 2'b00}, held stable until memReqReady; on memReqReady go to WAIT and clear the timeout counter.
REQ-019 In WAIT on memRspValid, write memRspData to insLineOut[32*wordIdx+31 : 32*wordIdx], set wordIdx=(wordIdx+1) mod 4 and wordCnt+=1; go to DONE if wordCnt was 3, otherwise go to REQ.
REQ-020 A response in the same cycle as its request handshake SHALL NOT be taken; memRspValid outside WAIT SHALL be ignored.
REQ-021 DONE: insLineValidOut=1 for exactly one cycle; the next state is IDLE; insLineOut holds its value until the next fill writes it.
REQ-022 WAIT timeout: if the counter reaches TIMEOUT_CYCLES without memRspValid, pulse fillErr for one cycle, go to IDLE, and do not assert insLineValidOut.
REQ-023 missReq while not in IDLE SHALL be ignored (missReady=0); it is not queued.
REQ-024 Minimum latency, with memReqReady and memRspValid always high: miss accepted at cycle T, insLineValidOut at T+9.
REQ-025 memReqValid and insLineValidOut SHALL never be high in the same cycle; at most one memory request is outstanding.

Reset
REQ-026 While Rst=1 at a clock edge, state=IDLE and wordCnt, wordIdx, timeout counter, insLineOut and fillPc =0.
REQ-027 Outputs after reset: missReady=1, memReqValid=0, memReqAddr=0, insLineValidOut=0, fillErr=0.
REQ-028 Rst mid-fill SHALL abandon the fill with no valid or error pulse; a late response after reset is ignored per REQ-020.

Configuration
REQ-029 Macro IFU_CRITICAL_WORD_FIRST_EN defined: start index = missPc[3:2], and words are fetched in wrap order.
REQ-030 Macro not defined: start index = 0, and words are fetched in order 0,1,2,3 regardless of missPc[3:2].

Verification
REQ-031 Reset then idle: missReady=1, all other outputs 0; memRsp pulses produce no activity.
REQ-032 missPc=0x0000_1008, zero-wait memory returning addr^0xA5A5A5A5 -> addresses 0x1000, 0x1004, 0x1008, 0x100C (macro off) or 0x1008, 0x100C, 0x1000, 0x1004 (macro on); line={0xA5A5B5A9, 0xA5A5B5AD, 0xA5A5B5A1, 0xA5A5B5A5} (word3..word0) in both builds; valid pulse at T+9.
REQ-033 memReqReady low 3 cycles on the second word -> memReqAddr stable throughout; valid delayed 3 cycles to T+12.
REQ-034 No response, TIMEOUT_CYCLES=8 -> fillErr pulse at the 8th WAIT cycle, missReady=1 next cycle, no insLineValidOut.
REQ-035 Rst asserted in WAIT of the third word, then a new miss at 0x2000 -> only 0x2000-line addresses requested; line contains only new data.
REQ-036 missReq held high through a fill with missPc changing -> only the first missPc is fetched; the second is accepted only once back in IDLE.
